ahb_lite_master: RTL and testbench

Single-channel AHB-Lite initiator converting a simple valid/ready command stream into pipelined AHB SINGLE transfers and returning one response per command. It is the bus-master counterpart of the AHB-to-SSRAM slave bridge. It drives test sequencers, DMA-style engines and boot loaders onto the same AHB fabric. It keeps at most two transfers in flight: one in address phase and one in data phase.

---
 rtl/ahb_lite_master.sv | 130 +++++++++++++
 tb/tb_ahb_lite_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers, one response each.
// Latency: command accepted at edge E0 -> address phase cycle 1, data phase cycle 2, rsp_valid cycle 3 (zero waits).
// Backpressure: cmd_ready drops while the address phase is stalled by HREADY=0 or an ERROR cancel; responses cannot be stalled.
//
// Ports:
//   HCLK, HRESETn                  bus clock, async active-low reset
//   HADDR/HTRANS/HSIZE/HWRITE      address-phase controls from the AP register
//   HBURST/HPROT                   constant SINGLE / data-privileged
//   HWDATA                         data-phase write data from the DP register
//   HREADY/HRESP/HRDATA            slave response
//   cmd_*                          command stream (valid/ready)
//   rsp_*                          one-cycle response pulse per command, in order
module ahb_lite_master #(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    input  logic [31:0]   HRDATA,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_size,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [2:0]    hsize;
        logic          write;
        logic [31:0]   wdata;
    } ap_t;

    typedef struct packed {
        logic        vld;
        logic        write;
        logic [31:0] wdata;
    } dp_t;

    ap_t        ap;
    dp_t        dp;
    logic       err_cancel;
    logic       issue;
    logic       addr_done;
    logic       data_done;
    logic       accept;
    logic [2:0] hsize_in;

    // The AP command is only driven onto the bus while no ERROR cancel is pending.
    assign issue     = ap.vld && !err_cancel;
    assign addr_done = HREADY && issue;
    assign data_done = HREADY && dp.vld;
    assign cmd_ready = !ap.vld || (HREADY && !err_cancel);
    assign accept    = cmd_valid && cmd_ready;

    // Size code 3 has no 64-bit meaning on a 32-bit bus; fold it to word.
    always_comb begin
        hsize_in = {1'b0, cmd_size};
        if (cmd_size == 2'd3) begin
            hsize_in = 3'd2;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap         <= '0;
            dp         <= '0;
            err_cancel <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            // Only the valid bit is cleared when AP drains, so the address
            // controls keep their last value on an idle bus.
            if (accept) begin
                ap.vld   <= 1'b1;
                ap.addr  <= cmd_addr;
                ap.hsize <= hsize_in;
                ap.write <= cmd_write;
                ap.wdata <= cmd_wdata;
            end else if (addr_done) begin
                ap.vld <= 1'b0;
            end

            // DP advances only on HREADY; wdata is kept otherwise so HWDATA
            // holds through wait states and after the last transfer.
            if (HREADY) begin
                dp.vld <= addr_done;
                if (addr_done) begin
                    dp.write <= ap.write;
                    dp.wdata <= ap.wdata;
                end
            end

            // First ERROR cycle (HREADY=0) cancels the pending address phase
            // for the second ERROR cycle, as the two-cycle ERROR response requires.
            if (HREADY) begin
                err_cancel <= 1'b0;
            end else if (dp.vld && HRESP) begin
                err_cancel <= 1'b1;
            end

            rsp_valid <= data_done;
            rsp_err   <= data_done && HRESP;
            rsp_rdata <= (data_done && !dp.write && !HRESP) ? HRDATA : 32'h0;
        end
    end

    assign HTRANS = issue ? 2'b10 : 2'b00;
    assign HADDR  = ap.addr;
    assign HSIZE  = ap.hsize;
    assign HWRITE = ap.write;
    assign HWDATA = dp.wdata;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: table of single transfers plus hand-written
// sequences for pipelining, wait states, ERROR cancel and mid-transfer reset.
// Responses are checked through an in-order scoreboard that also fixes the expected cycle.
module tb_ahb_lite_master;
    localparam int AW = 32;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [31:0]   HWDATA;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;
    logic [31:0]   HRDATA;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [1:0]    cmd_size = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    ahb_lite_master #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Slave model: latch the address of each completed address phase and
    // return 0x11 * (word index + 1) as read data in the data phase.
    logic [AW-1:0] s_addr;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) s_addr <= '0;
        else if (HREADY && HTRANS == 2'b10) s_addr <= HADDR;
    end
    assign HRDATA = 32'h11 * ({2'b00, s_addr[31:2]} + 32'd1);

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [2:0]  exp_hsize;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int c, input logic e, input logic [31:0] d);
        exp_t x;
        x.cyc = c;
        x.err = e;
        x.rdata = d;
        sb.push_back(x);
    endtask

    // Response monitor: every pulse must match the head of the scoreboard.
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got response at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    task automatic run_single(input vec_t v);
        int a;
        step();
        issue(v.wr, v.addr, v.size, v.wdata);
        sample();
        chk("single_cmd_ready", 32'(cmd_ready), 32'h1);
        step();
        a = cyc;
        cmd_valid = 1'b0;
        push(a + 2, 1'b0, v.wr ? 32'h0 : v.exp_rdata);
        sample();
        chk("single_htrans", 32'(HTRANS), 32'h2);
        chk("single_haddr", HADDR, v.addr);
        chk("single_hsize", 32'(HSIZE), 32'(v.exp_hsize));
        chk("single_hwrite", 32'(HWRITE), 32'(v.wr));
        step();
        sample();
        chk("single_dphase_htrans", 32'(HTRANS), 32'h0);
        if (v.wr) chk("single_hwdata", HWDATA, v.wdata);
        idle(3);
    endtask

    initial begin
        int a;
        vt[0] = '{1'b1, 32'h100, 2'd2, 32'hDEADBEEF, 3'd2, 32'h0};
        vt[1] = '{1'b1, 32'h003, 2'd0, 32'hAB000000, 3'd0, 32'h0};
        vt[2] = '{1'b0, 32'h010, 2'd3, 32'h0,        3'd2, 32'h55};
        vt[3] = '{1'b0, 32'h006, 2'd1, 32'h0,        3'd1, 32'h22};
        vt[4] = '{1'b1, 32'h040, 2'd3, 32'h12345678, 3'd2, 32'h0};
        vt[5] = '{1'b0, 32'h000, 2'd0, 32'h0,        3'd0, 32'h11};

        // Reset state
        sample();
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("hburst", 32'(HBURST), 32'h0);
        chk("hprot", 32'(HPROT), 32'h3);
        step();
        HRESETn = 1'b1;
        idle(2);

        // Single transfers, zero waits
        for (int i = 0; i < 6; i++) run_single(vt[i]);

        // Back-to-back reads 0x0, 0x4, 0x8
        step();
        issue(1'b0, 32'h0, 2'd2, 32'h0);
        step();
        a = cyc;
        push(a + 2, 1'b0, 32'h11);
        issue(1'b0, 32'h4, 2'd2, 32'h0);
        sample();
        chk("b2b_htrans0", 32'(HTRANS), 32'h2);
        chk("b2b_haddr0", HADDR, 32'h0);
        chk("b2b_ready0", 32'(cmd_ready), 32'h1);
        step();
        push(a + 3, 1'b0, 32'h22);
        issue(1'b0, 32'h8, 2'd2, 32'h0);
        sample();
        chk("b2b_htrans1", 32'(HTRANS), 32'h2);
        chk("b2b_haddr1", HADDR, 32'h4);
        step();
        push(a + 4, 1'b0, 32'h33);
        cmd_valid = 1'b0;
        sample();
        chk("b2b_htrans2", 32'(HTRANS), 32'h2);
        chk("b2b_haddr2", HADDR, 32'h8);
        step();
        sample();
        chk("b2b_idle", 32'(HTRANS), 32'h0);
        idle(4);

        // Two wait states on the first of two reads
        step();
        issue(1'b0, 32'h20, 2'd2, 32'h0);
        step();
        a = cyc;
        issue(1'b0, 32'h24, 2'd2, 32'h0);
        push(a + 4, 1'b0, 32'h99);
        push(a + 5, 1'b0, 32'hAA);
        sample();
        chk("ws_haddr0", HADDR, 32'h20);
        step();
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        for (int w = 0; w < 2; w++) begin
            sample();
            chk("ws_cmd_ready", 32'(cmd_ready), 32'h0);
            chk("ws_htrans", 32'(HTRANS), 32'h2);
            chk("ws_haddr", HADDR, 32'h24);
            step();
        end
        HREADY = 1'b1;
        idle(5);

        // ERROR on read 0x200 cancels the pending write 0x204
        step();
        issue(1'b0, 32'h200, 2'd2, 32'h0);
        step();
        a = cyc;
        issue(1'b1, 32'h204, 2'd2, 32'h5555AAAA);
        step();
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        HRESP = 1'b1;
        push(a + 3, 1'b1, 32'h0);
        push(a + 5, 1'b0, 32'h0);
        step();
        HREADY = 1'b1;
        sample();
        chk("err_htrans_idle", 32'(HTRANS), 32'h0);
        chk("err_cmd_ready", 32'(cmd_ready), 32'h0);
        step();
        HRESP = 1'b0;
        sample();
        chk("err_reissue_htrans", 32'(HTRANS), 32'h2);
        chk("err_reissue_haddr", HADDR, 32'h204);
        chk("err_reissue_hwrite", 32'(HWRITE), 32'h1);
        step();
        sample();
        chk("err_reissue_hwdata", HWDATA, 32'h5555AAAA);
        idle(4);

        // One-cycle ERROR with HREADY=1: reported, no cancel
        step();
        issue(1'b0, 32'h30, 2'd2, 32'h0);
        step();
        a = cyc;
        issue(1'b0, 32'h34, 2'd2, 32'h0);
        push(a + 2, 1'b1, 32'h0);
        push(a + 3, 1'b0, 32'hEE);
        step();
        cmd_valid = 1'b0;
        HRESP = 1'b1;
        sample();
        chk("perr_htrans", 32'(HTRANS), 32'h2);
        chk("perr_haddr", HADDR, 32'h34);
        step();
        HRESP = 1'b0;
        idle(4);

        // Reset pulsed during a wait state: in-flight read dropped
        step();
        issue(1'b0, 32'h40, 2'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        HREADY = 1'b0;
        step();
        HRESETn = 1'b0;
        #1;
        chk("mrst_htrans", 32'(HTRANS), 32'h0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'h1);
        step();
        HREADY = 1'b1;
        step();
        HRESETn = 1'b1;
        sample();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            sample();
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("post_rst_htrans", 32'(HTRANS), 32'h0);
        end

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
